vga_update_scheduler: RTL and testbench

Frame-synchronous controller sitting beside `display_vga`: it watches the timing generator's scan position and sequences host configuration updates so they take effect only at the start of vertical blanking (tear-free). It also emits a per-frame start pulse, a wrapping frame counter and an optional blink tick for the clock renderer. All outputs are registered; `display_vga` itself is not modified.

---
 rtl/vga_sched_pkg.sv | 18 +
 rtl/vga_update_scheduler_if.sv | 31 +++
 rtl/vga_pos_edge_detect.sv | 36 +++
 rtl/vga_update_scheduler.sv | 179 +++++++++++++++++
 tb/tb_vga_update_scheduler.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/vga_sched_pkg.sv
// Shared types and default 640x480 timing constants for the VGA update scheduler.
package vga_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PENDING   = 2'd1,
    WAIT_DROP = 2'd2
  } sched_state_t;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;
  localparam int CFG_W       = 16;
  localparam int POS_W       = 10;
  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/vga_update_scheduler_if.sv
// Scan-position inputs, host update handshake and frame-status outputs of the scheduler.
interface vga_update_scheduler_if #(
  parameter int CFG_W = vga_sched_pkg::CFG_W,
  parameter int POS_W = vga_sched_pkg::POS_W
);
  import vga_sched_pkg::*;

  logic [POS_W-1:0]       horizPos;
  logic [POS_W-1:0]       vertPos;
  logic                   active;
  logic                   upd_req;
  logic [CFG_W-1:0]       upd_data;
  logic                   upd_ack;
  logic                   upd_busy;
  logic [CFG_W-1:0]       cfg_out;
  logic                   frame_start;
  logic                   in_vblank;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   blink;

  modport master (
    output horizPos, vertPos, active, upd_req, upd_data,
    input  upd_ack, upd_busy, cfg_out, frame_start, in_vblank, frame_cnt, blink
  );

  modport slave (
    input  horizPos, vertPos, active, upd_req, upd_data,
    output upd_ack, upd_busy, cfg_out, frame_start, in_vblank, frame_cnt, blink
  );

endinterface

// File: rtl/vga_pos_edge_detect.sv
// One-cycle event when the scan position first lands on (H_MATCH, V_MATCH);
// a position held static does not re-fire.
module vga_pos_edge_detect
  import vga_sched_pkg::*;
#(
  parameter int POS_W   = vga_sched_pkg::POS_W,
  parameter int H_MATCH = 0,
  parameter int V_MATCH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [POS_W-1:0] i_h,
  input  logic [POS_W-1:0] i_v,
  output logic             o_event
);

  localparam logic [POS_W-1:0] H_M = POS_W'(H_MATCH);
  localparam logic [POS_W-1:0] V_M = POS_W'(V_MATCH);

  logic w_match;
  logic r_prev_match;

  assign w_match = (i_h == H_M) && (i_v == V_M);

  // Previous-cycle match flag used to suppress repeats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_match <= 1'b0;
    end else begin
      r_prev_match <= w_match;
    end
  end

  assign o_event = w_match && !r_prev_match;

endmodule

// File: rtl/vga_update_scheduler.sv
// Tear-free config update sequencer: host words commit at the start of vblank.
// Optional blink tick built only when VGA_SCHED_BLINK_EN is defined.
module vga_update_scheduler #(
  parameter int                H_ACTIVE     = vga_sched_pkg::H_ACTIVE,
  parameter int                V_ACTIVE     = vga_sched_pkg::V_ACTIVE,
  parameter int                CFG_W        = vga_sched_pkg::CFG_W,
  parameter logic [CFG_W-1:0]  CFG_RESET    = {CFG_W{1'b0}},
  parameter int                BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   sys_rst_n,
  vga_update_scheduler_if.slave  bus
);
  import vga_sched_pkg::*;

  localparam logic [POS_W-1:0] V_ACT_POS = POS_W'(V_ACTIVE);

  sched_state_t           r_state;
  sched_state_t           w_next;
  logic                   w_accept;
  logic                   w_commit;
  logic                   w_org_evt;
  logic                   w_vb_evt;
  logic [CFG_W-1:0]       r_pending;
  logic [CFG_W-1:0]       r_cfg;
  logic                   r_ack;
  logic                   r_busy;
  logic                   r_frame_start;
  logic                   r_in_vblank;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  vga_pos_edge_detect #(
    .POS_W   (POS_W),
    .H_MATCH (0),
    .V_MATCH (0)
  ) u_org_detect (
    .clk     (clk),
    .rst_n   (sys_rst_n),
    .i_h     (bus.horizPos),
    .i_v     (bus.vertPos),
    .o_event (w_org_evt)
  );

  vga_pos_edge_detect #(
    .POS_W   (POS_W),
    .H_MATCH (0),
    .V_MATCH (V_ACTIVE)
  ) u_vb_detect (
    .clk     (clk),
    .rst_n   (sys_rst_n),
    .i_h     (bus.horizPos),
    .i_v     (bus.vertPos),
    .o_event (w_vb_evt)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus accept/commit strobes; an accept on a vb cycle waits a frame.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.upd_req) begin
          w_next   = PENDING;
          w_accept = 1'b1;
        end else begin
          w_next   = IDLE;
        end
      end
      PENDING: begin
        if (w_vb_evt) begin
          w_next   = WAIT_DROP;
          w_commit = 1'b1;
        end else begin
          w_next   = PENDING;
        end
      end
      WAIT_DROP: begin
        if (!bus.upd_req) begin
          w_next = IDLE;
        end else begin
          w_next = WAIT_DROP;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Pending word, active config and handshake outputs.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pending <= {CFG_W{1'b0}};
      r_cfg     <= CFG_RESET;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pending <= bus.upd_data;
      end else begin
        r_pending <= r_pending;
      end
      if (w_commit) begin
        r_cfg <= r_pending;
      end else begin
        r_cfg <= r_cfg;
      end
      r_ack  <= w_commit;
      r_busy <= (w_next == PENDING);
    end
  end

  // Frame pulse, frame counter and vblank flag.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_frame_start <= 1'b0;
      r_in_vblank   <= 1'b0;
      r_frame_cnt   <= {FRAME_CNT_W{1'b0}};
    end else begin
      r_frame_start <= w_org_evt;
      r_in_vblank   <= (bus.vertPos >= V_ACT_POS) && !bus.active;
      if (w_org_evt) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
    end
  end

`ifdef VGA_SCHED_BLINK_EN
  localparam int BC_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int BLINK_LAST = BLINK_FRAMES - 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_LAST);

  logic [BC_W-1:0] r_blink_cnt;
  logic            r_blink;

  // Blink half-period counter, advanced once per frame.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_blink_cnt <= {BC_W{1'b0}};
      r_blink     <= 1'b0;
    end else if (w_org_evt) begin
      if (r_blink_cnt == BC_LAST) begin
        r_blink_cnt <= {BC_W{1'b0}};
        r_blink     <= !r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + {{(BC_W-1){1'b0}}, 1'b1};
        r_blink     <= r_blink;
      end
    end else begin
      r_blink_cnt <= r_blink_cnt;
      r_blink     <= r_blink;
    end
  end

  assign bus.blink = r_blink;
`else
  assign bus.blink = 1'b0;
`endif

  assign bus.upd_ack     = r_ack;
  assign bus.upd_busy    = r_busy;
  assign bus.cfg_out     = r_cfg;
  assign bus.frame_start = r_frame_start;
  assign bus.in_vblank   = r_in_vblank;
  assign bus.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_update_scheduler.sv
// Directed + randomized bench for vga_update_scheduler with a frame-level reference model.
module tb_vga_update_scheduler;

  localparam int BLINK_N = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_update_scheduler_if #(.CFG_W(16), .POS_W(10)) bus();

  vga_update_scheduler #(
    .H_ACTIVE     (640),
    .V_ACTIVE     (480),
    .CFG_W        (16),
    .CFG_RESET    (16'h0000),
    .BLINK_FRAMES (BLINK_N)
  ) dut (
    .clk       (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model: protocol phase flags, committed word and total frames seen.
  bit          m_prev_org, m_prev_vb;
  bit          m_pending, m_wait_drop;
  logic [15:0] m_word, m_cfg;
  bit          m_ack, m_fs, m_vbl;
  int          m_frames;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_org = 0; m_prev_vb = 0; m_pending = 0; m_wait_drop = 0;
    m_word = 16'h0000; m_cfg = 16'h0000;
    m_ack = 0; m_fs = 0; m_vbl = 0; m_frames = 0;
  endtask

  task automatic model_edge();
    bit org, vb, vb_ev;
    org   = (bus.horizPos == 10'd0) && (bus.vertPos == 10'd0);
    vb    = (bus.horizPos == 10'd0) && (bus.vertPos == 10'd480);
    m_fs  = org && !m_prev_org;
    vb_ev = vb && !m_prev_vb;
    m_prev_org = org;
    m_prev_vb  = vb;
    m_ack = 0;
    if (m_pending) begin
      if (vb_ev) begin
        m_cfg = m_word; m_ack = 1; m_pending = 0; m_wait_drop = 1;
      end
    end else if (m_wait_drop) begin
      if (!bus.upd_req) m_wait_drop = 0;
    end else if (bus.upd_req) begin
      m_word = bus.upd_data; m_pending = 1;
    end
    if (m_fs) m_frames++;
    m_vbl = (bus.vertPos >= 10'd480);
  endtask

  function automatic logic exp_blink();
`ifdef VGA_SCHED_BLINK_EN
    return ((m_frames / BLINK_N) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(input string ctx);
    chk({ctx, ".upd_ack"},     {15'd0, bus.upd_ack},     {15'd0, m_ack});
    chk({ctx, ".upd_busy"},    {15'd0, bus.upd_busy},    {15'd0, m_pending});
    chk({ctx, ".cfg_out"},     bus.cfg_out,              m_cfg);
    chk({ctx, ".frame_start"}, {15'd0, bus.frame_start}, {15'd0, m_fs});
    chk({ctx, ".in_vblank"},   {15'd0, bus.in_vblank},   {15'd0, m_vbl});
    chk({ctx, ".frame_cnt"},   {8'd0, bus.frame_cnt},    16'(m_frames % 256));
    chk({ctx, ".blink"},       {15'd0, bus.blink},       {15'd0, exp_blink()});
  endtask

  task automatic step(input string ctx, input int h, input int v, input bit req, input logic [15:0] d);
    @(negedge clk);
    bus.horizPos = 10'(h);
    bus.vertPos  = 10'(v);
    bus.active   = (h < 640) && (v < 480);
    bus.upd_req  = req;
    bus.upd_data = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all(ctx);
  endtask

  task automatic do_reset(input string ctx);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    @(negedge clk);
    bus.upd_req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input string ctx, input bit req, input logic [15:0] d);
    step(ctx, 0, 0, req, d);
    repeat (2) step(ctx, $urandom_range(1, 799), $urandom_range(1, 479), req, d);
    step(ctx, 0, 480, req, d);
    repeat (2) step(ctx, $urandom_range(0, 799), $urandom_range(481, 524), req, d);
  endtask

  initial begin
    bus.horizPos = 10'd10; bus.vertPos = 10'd10; bus.active = 1'b1;
    bus.upd_req  = 1'b0;   bus.upd_data = 16'h0000;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3) run_frame("frames", 1'b0, 16'h0000);
    chk("three_frames_cnt", {8'd0, bus.frame_cnt}, 16'd3);

    step("upd_a5", 0, 0, 1'b0, 16'h0000);
    step("upd_a5", 3, 100, 1'b1, 16'hA5A5);
    chk("busy_after_req", {15'd0, bus.upd_busy}, 16'd1);
    step("upd_a5", 7, 200, 1'b1, 16'(($urandom)));
    step("upd_a5", 0, 480, 1'b1, 16'(($urandom)));
    chk("ack_at_vb", {15'd0, bus.upd_ack}, 16'd1);
    chk("cfg_a5a5", bus.cfg_out, 16'hA5A5);
    step("upd_a5", 1, 481, 1'b1, 16'h0000);

    repeat (3) run_frame("hold_req", 1'b1, 16'h5555);
    step("redo", 5, 490, 1'b0, 16'h0000);
    step("redo", 6, 491, 1'b1, 16'h1234);
    run_frame("redo", 1'b1, 16'h1234);
    chk("cfg_1234", bus.cfg_out, 16'h1234);
    step("redo", 8, 20, 1'b0, 16'h0000);

    step("req_on_vb", 0, 0, 1'b0, 16'h0000);
    step("req_on_vb", 2, 50, 1'b0, 16'h0000);
    step("req_on_vb", 0, 480, 1'b1, 16'hBEEF);
    step("req_on_vb", 0, 480, 1'b1, 16'hBEEF);
    chk("no_same_frame_commit", bus.cfg_out, 16'h1234);
    step("req_on_vb", 4, 500, 1'b1, 16'hBEEF);
    run_frame("req_on_vb", 1'b1, 16'hBEEF);
    chk("cfg_beef", bus.cfg_out, 16'hBEEF);
    step("req_on_vb", 3, 10, 1'b0, 16'h0000);

    repeat (3) step("static_org", 0, 0, 1'b0, 16'h0000);

    step("rst_pend", 3, 100, 1'b1, 16'hC3C3);
    step("rst_pend", 4, 101, 1'b1, 16'hC3C3);
    do_reset("async_rst");
    repeat (2) run_frame("after_rst", 1'b0, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      int kind;
      kind = $urandom_range(0, 5);
      if (kind == 0)      step("rand", 0, 0,   $urandom_range(0, 3) != 0, 16'($urandom));
      else if (kind == 1) step("rand", 0, 480, $urandom_range(0, 3) != 0, 16'($urandom));
      else step("rand", $urandom_range(0, 799), $urandom_range(0, 524),
                $urandom_range(0, 3) != 0, 16'($urandom));
    end

    do_reset("wrap_rst");
    for (int f = 0; f < 257; f++) run_frame("wrap", 1'b0, 16'h0000);
    chk("frame_cnt_wrap", {8'd0, bus.frame_cnt}, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
